// File: rtl/sseg_pkg.sv
// Shared types, segment encodings and helpers for the seven-segment scan driver.
package sseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is held off.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam logic [7:0]  SEG_DASH   = 8'hBF;
  localparam logic [13:0] MAX_VALUE  = 14'd9999;
  localparam logic [3:0]  CONV_ITERS = 4'd14;

  function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digits above the most significant nonzero digit are blanked; 0 keeps digit 0.
  function automatic logic [7:0] digit_seg(input logic [15:0] bcd, input logic over,
                                           input logic [1:0] idx);
    logic [1:0] msd;
    logic [3:0] nib;
    logic [7:0] s;
    msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i[1:0];
    end
    nib = bcd[4*idx +: 4];
    s = SEG_BLANK;
    for (int d = 0; d < 10; d++) begin
      if (nib == d[3:0]) s = SEG_DIGIT[d];
    end
    if (over) s = SEG_DASH;
    else if (idx > msd) s = SEG_BLANK;
    return s;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with sequential binary-to-BCD conversion.
// Handshake: a write is taken on any clk edge where data_we = 1 and busy = 0; writes while busy = 1 are dropped.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] data_in,
  input  logic        data_we,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output state_t      dbg_state
);

  state_t      r_state;
  logic [13:0] r_shift;
  logic [15:0] r_bcd;
  logic [3:0]  r_iter;
  logic        r_over_pend;
  logic [15:0] r_disp;
  logic        r_over;
  logic [1:0]  r_idx;
  logic [7:0]  r_seg;
  logic [3:0]  r_an;

  logic        w_tick;
  logic [15:0] w_bcd_adj;
  logic [1:0]  w_idx_next;
  logic [15:0] w_disp_next;
  logic        w_over_next;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // The LOAD value is forwarded so seg reflects the new value on the commit edge.
  always_comb begin
    w_bcd_adj   = bcd_add3(r_bcd);
    w_idx_next  = w_tick ? r_idx + 2'd1 : r_idx;
    w_disp_next = (r_state == ST_LOAD) ? r_bcd : r_disp;
    w_over_next = (r_state == ST_LOAD) ? r_over_pend : r_over;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bcd       <= '0;
      r_iter      <= '0;
      r_over_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_we) begin
            r_state <= ST_CONV;
            r_bcd   <= '0;
            r_iter  <= '0;
            if (data_in > MAX_VALUE) begin
              r_shift     <= '0;
              r_over_pend <= 1'b1;
            end else begin
              r_shift     <= data_in;
              r_over_pend <= 1'b0;
            end
          end
        end
        ST_CONV: begin
          {r_bcd, r_shift} <= {w_bcd_adj[14:0], r_shift, 1'b0};
          r_iter           <= r_iter + 4'd1;
          if (r_iter == CONV_ITERS - 4'd1) r_state <= ST_LOAD;
        end
        ST_LOAD: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp <= '0;
      r_over <= 1'b0;
      r_idx  <= 2'd0;
      r_seg  <= SEG_DIGIT[0];
      r_an   <= 4'b1110;
    end else begin
      r_disp <= w_disp_next;
      r_over <= w_over_next;
      r_idx  <= w_idx_next;
      r_seg  <= digit_seg(w_disp_next, w_over_next, w_idx_next);
      r_an   <= ~(4'b0001 << w_idx_next);
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign seg       = r_seg;
  assign an        = r_an;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver with a fast scan rate and a scan-order scoreboard.
module tb_sseg_scan_driver;
  import sseg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] data_in = '0;
  logic        data_we = 1'b0;
  logic        busy;
  logic [7:0]  seg;
  logic [3:0]  an;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  sseg_scan_driver #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_we   (data_we),
    .busy      (busy),
    .seg       (seg),
    .an        (an),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Independent decimal model of what each digit position should show.
  function automatic logic [7:0] model_seg(input int v, input int k);
    logic [7:0] tbl [0:9];
    int d [0:3];
    int msd;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (v > 9999) return 8'hBF;
    d[0] = v % 10; d[1] = (v / 10) % 10; d[2] = (v / 100) % 10; d[3] = (v / 1000) % 10;
    msd = 0;
    for (int i = 1; i < 4; i++) if (d[i] != 0) msd = i;
    if (k > msd) return 8'hFF;
    return tbl[d[k]];
  endfunction

  task automatic push_scan(input int v);
    logic [3:0] an_tbl [0:3];
    an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int k = 0; k < 4; k++) exp_q.push_back({an_tbl[k], model_seg(v, k)});
  endtask

  // Pops four entries, sampled from digit 0 through digit 3 on negative edges.
  task automatic check_scan(input string name);
    logic [11:0] exp;
    logic [3:0]  prev_an;
    int n;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      prev_an = an;
      if (k == 0) begin
        while (an !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
      end else begin
        while (an === prev_an && n < 10) begin @(negedge clk); n++; end
      end
      exp = exp_q.pop_front();
      checks++;
      if ({an, seg} !== exp) begin
        errors++;
        $display("FAIL %s digit%0d: got an=%b seg=%h, want an=%b seg=%h",
                 name, k, an, seg, exp[11:8], exp[7:0]);
      end
    end
  endtask

  task automatic do_write(input int v);
    @(negedge clk);
    data_in = v[13:0];
    data_we = 1'b1;
    @(posedge clk);
    #1 data_we = 1'b0;
  endtask

  // Counts negative edges with busy high after the accepting edge; optionally fires a stray write.
  task automatic measure_busy(input string name, input int stray_at, input int stray_val);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (n == stray_at) begin data_in = stray_val[13:0]; data_we = 1'b1; end
      else data_we = 1'b0;
      if (busy !== 1'b1 || n >= 40) break;
      n++;
    end
    data_we = 1'b0;
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL %s busy_len: got %0d cycles, want 15", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || an !== 4'b1110 || seg !== 8'hC0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b an=%b seg=%h st=%0d, want 0 1110 c0 0",
               busy, an, seg, dbg_state);
    end
    rst = 1'b0;
    push_scan(0);
    check_scan("reset_scan");
  endtask

  task automatic test_convert(input int v, input string name);
    do_write(v);
    measure_busy(name, -1, 0);
    push_scan(v);
    check_scan(name);
  endtask

  task automatic test_drop_while_busy();
    do_write(42);
    measure_busy("drop", 3, 9999);
    push_scan(42);
    check_scan("drop");
  endtask

  task automatic test_reset_mid_conv();
    do_write(5555);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || an !== 4'b1110 || seg !== 8'hC0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b an=%b seg=%h, want 0 1110 c0", busy, an, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    push_scan(0);
    check_scan("mid_reset_scan");
    test_convert(8, "after_reset");
  endtask

  initial begin
    test_reset();
    test_convert(1234, "w1234");
    test_convert(7, "w7");
    test_convert(12000, "w12000");
    test_convert(0, "w0");
    test_drop_while_busy();
    test_convert(9999, "w9999");
    test_convert(1000, "w1000");
    test_convert(305, "w305");
    for (int i = 0; i < 4; i++) test_convert($urandom_range(0, 16383), "rand");
    test_reset_mid_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
